corefifo_gray_conv_pipe: RTL and testbench

Pipelined, multi-channel Gray/binary pointer converter for the COREFIFO pointer path.
- Each accepted word is converted Gray->binary or binary->Gray, selected per word.
- The Gray->binary XOR chain is split across PIPE_STAGES registers to meet timing at wide ADDRWIDTH.
- In Gray->binary mode, each word is checked against the last value seen on its channel. A change of more than one bit is flagged as a step error and counted; this catches CDC pointer corruption.

---
 rtl/corefifo_gray_pkg.sv | 24 ++
 rtl/corefifo_gray_step_chk.sv | 41 ++++
 rtl/corefifo_gray_conv_pipe.sv | 135 +++++++++++++
 tb/tb_corefifo_gray_conv_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/corefifo_gray_pkg.sv
// corefifo_gray_pkg: shared constants and sizing helpers for the Gray/binary pointer converter
package corefifo_gray_pkg;

    localparam logic GRAY2BIN = 1'b0;
    localparam logic BIN2GRAY = 1'b1;

    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int chunk(input int w, input int p);
        return (w + p - 1) / p;
    endfunction

    function automatic int popcount(input logic [63:0] x);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/corefifo_gray_step_chk.sv
// corefifo_gray_step_chk: per-channel Gray pointer history and multi-bit step detection
module corefifo_gray_step_chk
    import corefifo_gray_pkg::*;
#(
    parameter int W      = 4,
    parameter int NUM_CH = 1,
    parameter int CHW    = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           valid_i,
    input  logic           mode_i,
    input  logic [CHW-1:0] ch_i,
    input  logic [W-1:0]   data_i,
    output logic           step_err_o
);

    localparam int N = 1 << CHW;

    logic [W-1:0] last_q [N];
    logic [N-1:0] seen_q;
    logic         track;

    // Only in-range Gray words participate in history tracking
    always_comb begin
        track      = (mode_i == GRAY2BIN) && (32'(ch_i) < NUM_CH);
        step_err_o = track && seen_q[ch_i] && (popcount(64'(data_i ^ last_q[ch_i])) > 1);
    end

    // Record every accepted tracked word, erroneous or not, as the new reference
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) last_q[i] <= '0;
            seen_q <= '0;
        end else if (valid_i && track) begin
            last_q[ch_i] <= data_i;
            seen_q[ch_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/corefifo_gray_conv_pipe.sv
// corefifo_gray_conv_pipe: elastic multi-stage Gray<->binary pointer converter with step-error counting
module corefifo_gray_conv_pipe
    import corefifo_gray_pkg::*;
#(
    parameter  int ADDRWIDTH   = 3,
    parameter  int NUM_CH      = 1,
    parameter  int PIPE_STAGES = 2,
    parameter  int ERR_CNT_W   = 16,
    localparam int W           = ADDRWIDTH + 1,
    localparam int CHW         = chw(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [CHW-1:0]       in_ch,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic [CHW-1:0]       out_ch,
    output logic [W-1:0]         out_data,
    output logic                 out_step_err,
    output logic [ERR_CNT_W-1:0] step_err_cnt
);

    localparam int P = PIPE_STAGES;
    localparam int C = chunk(W, P);

    logic [P-1:0]         v_q, m_q, e_q, ld, s_v, s_m, s_e;
    logic [W-1:0]         dat_q [P];
    logic [W-1:0]         dat_d [P];
    logic [W-1:0]         s_dat [P];
    logic [CHW-1:0]       ch_q  [P];
    logic [CHW-1:0]       s_ch  [P];
    logic [ERR_CNT_W-1:0] cnt_q;
    logic                 chk_err;

    corefifo_gray_step_chk #(
        .W      (W),
        .NUM_CH (NUM_CH),
        .CHW    (CHW)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (in_valid && ld[0]),
        .mode_i     (in_mode),
        .ch_i       (in_ch),
        .data_i     (in_data),
        .step_err_o (chk_err)
    );

    // Ready ripples back from the output: a stage loads when empty or when its successor takes its word
    always_comb begin : p_ld
        logic r;
        r = out_ready;
        for (int k = P - 1; k >= 0; k--) begin
            ld[k] = !v_q[k] || r;
            r     = ld[k];
        end
    end

    // Source of each stage: the input port for stage 0, the previous stage otherwise
    always_comb begin
        s_v[0]   = in_valid;
        s_m[0]   = in_mode;
        s_e[0]   = chk_err;
        s_ch[0]  = in_ch;
        s_dat[0] = in_data;
        for (int k = 1; k < P; k++) begin
            s_v[k]   = v_q[k-1];
            s_m[k]   = m_q[k-1];
            s_e[k]   = e_q[k-1];
            s_ch[k]  = ch_q[k-1];
            s_dat[k] = dat_q[k-1];
        end
    end

    // Each stage resolves its MSB-first chunk of the Gray XOR chain; binary->Gray is done in stage 0
    always_comb begin : p_conv
        logic [W-1:0] t;
        for (int k = 0; k < P; k++) begin
            t = s_dat[k];
            if (s_m[k] == GRAY2BIN) begin
                for (int i = W - 2; i >= 0; i--) begin
                    if (i <= W - 1 - k * C && i >= W - (k + 1) * C) t[i] = t[i+1] ^ t[i];
                end
            end else if (k == 0) begin
                t = t ^ (t >> 1);
            end
            dat_d[k] = t;
        end
    end

    // Stage registers advance independently; payload only changes when a valid word arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            m_q <= '0;
            e_q <= '0;
            for (int k = 0; k < P; k++) begin
                dat_q[k] <= '0;
                ch_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < P; k++) begin
                if (ld[k]) begin
                    v_q[k] <= s_v[k];
                    if (s_v[k]) begin
                        dat_q[k] <= dat_d[k];
                        m_q[k]   <= s_m[k];
                        e_q[k]   <= s_e[k];
                        ch_q[k]  <= s_ch[k];
                    end
                end
            end
        end
    end

    // Count erroneous words as they leave, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (v_q[P-1] && out_ready && e_q[P-1] && !(&cnt_q)) cnt_q <= cnt_q + ERR_CNT_W'(1);
    end

    assign in_ready     = ld[0];
    assign out_valid    = v_q[P-1];
    assign out_mode     = m_q[P-1];
    assign out_step_err = e_q[P-1];
    assign out_ch       = ch_q[P-1];
    assign out_data     = dat_q[P-1];
    assign step_err_cnt = cnt_q;

endmodule

// File: tb/tb_corefifo_gray_conv_pipe.sv
// tb_corefifo_gray_conv_pipe: scoreboard bench for the pipelined Gray/binary pointer converter
module tb_corefifo_gray_conv_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_mode = 1'b0;
    logic [1:0] in_ch = '0;
    logic [3:0] in_data = '0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_mode, out_step_err;
    logic [1:0] out_ch;
    logic [3:0] out_data;
    logic [1:0] step_err_cnt;

    typedef struct packed {
        logic       m;
        logic [1:0] c;
        logic [3:0] d;
        logic       e;
        logic [1:0] n;
    } item_t;

    item_t      sb [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         c0, lat;
    logic       cnt_chk = 1'b0;
    logic [1:0] cnt_exp = '0;

    corefifo_gray_conv_pipe #(
        .ADDRWIDTH   (3),
        .NUM_CH      (3),
        .PIPE_STAGES (2),
        .ERR_CNT_W   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_ch        (in_ch),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mode     (out_mode),
        .out_ch       (out_ch),
        .out_data     (out_data),
        .out_step_err (out_step_err),
        .step_err_cnt (step_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic m, input logic [1:0] c, input logic [3:0] d,
                        input logic [3:0] exp_d, input logic exp_e, input logic [1:0] exp_n,
                        input bit push = 1'b1);
        in_valid = 1'b1;
        in_mode  = m;
        in_ch    = c;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back('{m, c, exp_d, exp_e, exp_n});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1");
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cnt_chk = 1'b0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (cnt_chk) begin
                chk("err_cnt", 32'(step_err_cnt), 32'(cnt_exp));
                cnt_chk = 1'b0;
            end
            if (out_valid && out_ready) begin
                item_t it;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got out_data=%0h with nothing outstanding, required no output", out_data);
                end else begin
                    it = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(it.d));
                    chk("out_mode", 32'(out_mode), 32'(it.m));
                    chk("out_ch", 32'(out_ch), 32'(it.c));
                    chk("out_step_err", 32'(out_step_err), 32'(it.e));
                    cnt_exp = it.n;
                    cnt_chk = 1'b1;
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_out_mode", 32'(out_mode), 0);
        chk("rst_out_step_err", 32'(out_step_err), 0);
        chk("rst_err_cnt", 32'(step_err_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        send(1'b0, 2'd2, 4'b1101, 4'b1001, 1'b0, 2'd0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("latency", 32'(lat), 2);
        repeat (3) @(posedge clk);
        #1;
        send(1'b1, 2'd2, 4'b1001, 4'b1101, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        #1;

        c0 = cyc;
        for (int i = 0; i < 16; i++) send(1'b0, 2'd3, 4'(i), g2b(4'(i)), 1'b0, 2'd0);
        chk("stream_g2b_rate", 32'(cyc - c0), 16);
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(1'b1, 2'd0, 4'(i), b2g(4'(i)), 1'b0, 2'd0);
        chk("stream_b2g_rate", 32'(cyc - c0), 16);
        repeat (4) @(posedge clk);
        #1;

        send(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        send(1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        send(1'b0, 2'd0, 4'b0001, 4'b0001, 1'b0, 2'd0);
        send(1'b0, 2'd1, 4'b1111, 4'b1010, 1'b1, 2'd1);
        send(1'b0, 2'd0, 4'b0011, 4'b0010, 1'b0, 2'd1);
        send(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd2);
        repeat (4) @(posedge clk);
        #1;

        do_reset();
        send(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        send(1'b0, 2'd0, 4'b1111, 4'b1010, 1'b1, 2'd1);
        send(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd2);
        send(1'b0, 2'd0, 4'b1111, 4'b1010, 1'b1, 2'd3);
        send(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd3);
        send(1'b0, 2'd0, 4'b1111, 4'b1010, 1'b1, 2'd3);
        repeat (4) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(1'b1, 2'd1, 4'b0011, 4'b0010, 1'b0, 2'd3);
        send(1'b1, 2'd1, 4'b0101, 4'b0111, 1'b0, 2'd3);
        in_valid = 1'b1;
        in_mode  = 1'b1;
        in_ch    = 2'd1;
        in_data  = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_data", 32'(out_data), 32'(4'b0010));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b1, 2'd1, 4'b0110, 4'b0101, 1'b0, 2'd3);
        repeat (6) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(1'b0, 2'd0, 4'b0101, 4'b0000, 1'b0, 2'd0, 1'b0);
        send(1'b0, 2'd0, 4'b0110, 4'b0000, 1'b0, 2'd0, 1'b0);
        do_reset();
        @(negedge clk);
        chk("rst6_out_valid", 32'(out_valid), 0);
        chk("rst6_out_data", 32'(out_data), 0);
        chk("rst6_err_cnt", 32'(step_err_cnt), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(1'b0, 2'd0, 4'b1111, 4'b1010, 1'b0, 2'd0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words outstanding, required 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
